// File: rtl/rede_float_core_if.sv
// Host-side bus of one neuron core: sample in, result out, one-hot port strobes.
interface rede_float_core_if;
    logic signed [18:0] io_in;
    logic signed [27:0] io_out;
    logic        [3:0]  req_in;
    logic        [3:0]  out_en;

    modport slave  (input io_in, output io_out, req_in, out_en);
    modport master (output io_in, input io_out, req_in, out_en);
endinterface

// File: rtl/rede_float_core.sv
// Single-neuron core: fetch N_IN samples, multiply-accumulate against fixed
// weights, add bias, saturate to 28 bits, optional ReLU, post on port 0.
module rede_float_core #(
    parameter int                      N_IN    = 4,
    parameter int                      W_BITS  = 9,
    parameter logic [N_IN*W_BITS-1:0]  WEIGHTS = {9'sd3, -9'sd1, 9'sd2, 9'sd1},
    parameter logic signed [27:0]      BIAS    = 28'sd0,
    parameter bit                      RELU    = 1'b0
) (
    input logic              clk,
    input logic              rst,
    rede_float_core_if.slave bus
);
    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_MAC, S_OUT} state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx;
    logic signed [33:0]        acc;
    logic signed [18:0]        x_q;
    logic signed [W_BITS-1:0]  w_cur;
    logic signed [27:0]        prod;
    logic signed [33:0]        acc_sum;
    logic signed [33:0]        pre_sat;
    logic signed [27:0]        res;
    logic                      last;

    // Weight select, multiply and the post-processing of the final sum.
    always_comb begin
        w_cur   = $signed(WEIGHTS[idx*W_BITS +: W_BITS]);
        prod    = 28'(x_q) * 28'(w_cur);
        acc_sum = acc + 34'(prod);
        pre_sat = acc_sum + 34'(BIAS);
        last    = (idx == IDX_W'(N_IN - 1));
        if (pre_sat > 34'sd134217727)
            res = 28'sh7ff_ffff;
        else if (pre_sat < -34'sd134217728)
            res = 28'sh800_0000;
        else
            res = pre_sat[27:0];
        if (RELU && res[27])
            res = '0;
    end

    // Next-state logic; after OUT the core immediately starts the next pass.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   state_nxt = S_CAPT;
            S_CAPT:  state_nxt = S_MAC;
            S_MAC:   state_nxt = last ? S_OUT : S_REQ;
            S_OUT:   state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, datapath registers and registered strobes. The result is
    // loaded on the edge into OUT so io_out is already valid while out_en
    // is high; the accumulator is cleared on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            acc        <= '0;
            x_q        <= '0;
            bus.io_out <= '0;
            bus.req_in <= '0;
            bus.out_en <= '0;
        end else begin
            state      <= state_nxt;
            bus.req_in <= (state_nxt == S_REQ) ? 4'b0001 : 4'b0000;
            bus.out_en <= (state_nxt == S_OUT) ? 4'b0001 : 4'b0000;
            if (state == S_CAPT)
                x_q <= bus.io_in;
            if (state == S_MAC) begin
                if (last) begin
                    idx        <= '0;
                    acc        <= '0;
                    bus.io_out <= res;
                end else begin
                    idx <= idx + IDX_W'(1);
                    acc <= acc_sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_rede_float_core.sv
// Bench for rede_float_core: three cores in lockstep (defaults, ReLU,
// all-255 weights) fed the same samples; results checked from a scoreboard.
module tb_rede_float_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rede_float_core_if if0 ();
    rede_float_core_if if1 ();
    rede_float_core_if if2 ();

    rede_float_core u0 (.clk(clk), .rst(rst), .bus(if0));
    rede_float_core #(.RELU(1'b1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    rede_float_core #(.WEIGHTS({4{9'd255}})) u2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct { longint e0; longint e1; longint e2; } exp_t;

    int      n_chk = 0;
    int      n_err = 0;
    int      cyc   = 0;
    int      out_cyc = -1;
    bit      got_out = 1'b0;
    bit      req_d = 1'b0;
    int      viol_x = 0;
    int      viol_s = 0;
    longint  prev0 = 0;
    longint  smp[$];
    exp_t    expq[$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic longint model(input int k, input longint s[4]);
        longint wd[4] = '{1, 2, -1, 3};
        longint sum = 0;
        for (int i = 0; i < 4; i++)
            sum += s[i] * ((k == 2) ? 255 : wd[i]);
        if (sum > 134217727) sum = 134217727;
        if (sum < -134217728) sum = -134217728;
        if (k == 1 && sum < 0) sum = 0;
        return sum;
    endfunction

    task automatic push_pass(input longint a, input longint b, input longint c, input longint d);
        longint s[4] = '{a, b, c, d};
        exp_t   e;
        for (int i = 0; i < 4; i++) smp.push_back(s[i]);
        e.e0 = model(0, s);
        e.e1 = model(1, s);
        e.e2 = model(2, s);
        expq.push_back(e);
    endtask

    task automatic drive(input logic [18:0] v);
        if0.io_in = v;
        if1.io_in = v;
        if2.io_in = v;
    endtask

    // One clock: answer requests in the CAPT cycle, junk elsewhere, and
    // score every out_en pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            req_d = 1'b0;
            drive(19'($urandom));
        end else begin
            if (req_d) drive((smp.size() != 0) ? 19'(smp.pop_front()) : 19'd0);
            else       drive(19'($urandom));
            req_d = (if0.req_in == 4'b0001);
            if ((if0.req_in != 0 && if0.out_en != 0) || if0.req_in[3:1] != 0 || if0.out_en[3:1] != 0)
                viol_x++;
            if (longint'(if0.io_out) != prev0 && if0.out_en != 4'b0001)
                viol_s++;
            if (if0.out_en == 4'b0001) begin
                got_out = 1'b1;
                out_cyc = cyc;
                if (expq.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("out_u0", longint'(if0.io_out), e.e0);
                    check("out_u1", longint'(if1.io_out), e.e1);
                    check("out_u2", longint'(if2.io_out), e.e2);
                    check("oen_u1", longint'(if1.out_en), 1);
                    check("oen_u2", longint'(if2.out_en), 1);
                end
            end
        end
        prev0 = longint'(if0.io_out);
    endtask

    task automatic wait_out();
        got_out = 1'b0;
        for (int i = 0; i < 60 && !got_out; i++) tick();
        if (!got_out) check("out_timeout", 0, 1);
    endtask

    initial begin
        drive(19'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_out", longint'(if0.io_out), 0);
        check("rst_req_in", longint'(if0.req_in), 0);
        check("rst_out_en", longint'(if0.out_en), 0);

        push_pass(10, 20, 30, 40);
        push_pass(1, 1, 1, 1);
        push_pass(-10, 0, 0, 0);
        push_pass(262143, 262143, 262143, 262143);
        push_pass(-262144, -262144, -262144, -262144);

        rst = 1'b0;
        cyc = 0;
        prev0 = 0;
        check("c0_idle", longint'(if0.req_in), 0);
        tick();
        check("c1_req", longint'(if0.req_in), 1);
        tick();
        check("c2_noreq", longint'(if0.req_in), 0);
        wait_out();
        check("p1_cycle", out_cyc, 13);
        tick();
        check("c14_req", longint'(if0.req_in), 1);
        while (cyc < 25) tick();
        check("c25_hold", longint'(if0.io_out), 140);
        wait_out();
        check("p2_cycle", out_cyc, 26);
        wait_out();
        wait_out();
        wait_out();

        // Abort a pass during the MAC of sample 2.
        push_pass(7, 7, 7, 7);
        repeat (7) tick();
        check("abort_req3", longint'(if0.req_in), 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_io_out", longint'(if0.io_out), 0);
        check("mid_rst_req_in", longint'(if0.req_in), 0);
        check("mid_rst_out_en", longint'(if0.out_en), 0);
        smp.delete();
        expq.delete();
        push_pass(1, 1, 1, 1);
        rst = 1'b0;
        cyc = 0;
        prev0 = 0;
        check("re_c0_idle", longint'(if0.req_in), 0);
        tick();
        check("re_c1_req", longint'(if0.req_in), 1);
        wait_out();
        check("re_p_cycle", out_cyc, 13);

        check("strobe_excl", viol_x, 0);
        check("io_out_stable", viol_s, 0);
        check("sb_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
